// File: rtl/matvec_pkg.sv
// Shared types and sizing helpers for the matvec_engine matrix-vector block.
package matvec_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_COMPUTE = 3'd2,
    S_DRAIN   = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  localparam int DRAIN_CYCLES = 2;

  function automatic int load_beats(input int rows, input int cols);
    return cols + rows * cols;
  endfunction

  function automatic int compute_cycles(input int rows, input int cols);
    return rows + cols - 1;
  endfunction

endpackage

// File: rtl/matvec_mac.sv
// Two-stage unsigned multiply-accumulate lane with sticky overflow.
// Build option MATVEC_SAT_EN selects saturating instead of wrapping accumulation.
module matvec_mac
  import matvec_pkg::*;
#(
  parameter int DW = 8,
  parameter int AW = 24
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          clr,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [AW-1:0] acc,
  output logic          ovf
);

  logic [2*DW-1:0] prod_p1_q, prod_p1_d;
  logic            vld_p1_q, vld_p1_d;
  logic [AW-1:0]   acc_p2_q, acc_p2_d;
  logic            ovf_q, ovf_d;
  logic [AW:0]     sum;

  // Bit AW of the result carries the raw carry-out in both builds.
  function automatic logic [AW:0] accumulate(input logic [AW-1:0] acc_in,
                                             input logic [2*DW-1:0] p);
    logic [AW:0] s;
    s = {1'b0, acc_in} + {{(AW + 1 - 2 * DW){1'b0}}, p};
`ifdef MATVEC_SAT_EN
    if (s[AW]) s[AW-1:0] = '1;
`endif
    return s;
  endfunction

  always_comb begin
    prod_p1_d = {{DW{1'b0}}, a} * {{DW{1'b0}}, b};
    vld_p1_d  = en;
    sum       = accumulate(acc_p2_q, prod_p1_q);
    acc_p2_d  = acc_p2_q;
    ovf_d     = ovf_q;
    if (vld_p1_q) begin
      acc_p2_d = sum[AW-1:0];
      ovf_d    = ovf_q | sum[AW];
    end
    if (clr) begin
      vld_p1_d = 1'b0;
      acc_p2_d = '0;
      ovf_d    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prod_p1_q <= '0;
      vld_p1_q  <= 1'b0;
      acc_p2_q  <= '0;
      ovf_q     <= 1'b0;
    end else begin
      // stage 1: product
      prod_p1_q <= prod_p1_d;
      vld_p1_q  <= vld_p1_d;
      // stage 2: accumulate
      acc_p2_q  <= acc_p2_d;
      ovf_q     <= ovf_d;
    end
  end

  assign acc = acc_p2_q;
  assign ovf = ovf_q;

endmodule

// File: rtl/matvec_engine.sv
// Streams a COLS vector B then a ROWS x COLS matrix A, computes C = A*B on ROWS
// skewed MAC lanes. Build option MATVEC_SAT_EN (inside matvec_mac) saturates lanes.
module matvec_engine
  import matvec_pkg::*;
#(
  parameter int ROWS = 8,
  parameter int COLS = 8,
  parameter int DW   = 8,
  parameter int AW   = 24
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               clr,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DW-1:0]      in_data,
  output logic [ROWS*AW-1:0] c_out,
  output logic               c_valid,
  output logic [ROWS-1:0]    ovf,
  output logic               busy,
  output logic [2:0]         state
);

  localparam int NBEATS = load_beats(ROWS, COLS);
  localparam int NCOMP  = compute_cycles(ROWS, COLS);
  localparam int BW     = $clog2(NBEATS + 1);
  localparam int CW     = $clog2(NCOMP + DRAIN_CYCLES + 1);
  localparam int BIW    = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int AIW    = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1;

  state_t          state_q, state_d;
  logic [BW-1:0]   beat_q, beat_d;
  logic [CW-1:0]   cyc_q, cyc_d;
  logic            load_done_q, load_done_d;
  logic            in_ready_q, in_ready_d;
  logic            c_valid_q, c_valid_d;
  logic            busy_q, busy_d;
  logic [DW-1:0]   b_buf_q [COLS];
  logic [DW-1:0]   b_buf_d [COLS];
  logic [DW-1:0]   a_buf_q [ROWS*COLS];
  logic [DW-1:0]   a_buf_d [ROWS*COLS];
  logic [DW-1:0]   skew_q  [ROWS];
  logic [DW-1:0]   skew_d  [ROWS];
  logic [DW-1:0]   b_head;
  logic [DW-1:0]   lane_a  [ROWS];
  logic [DW-1:0]   lane_b  [ROWS];
  logic [ROWS-1:0] lane_en;
  logic            mac_clr;
  logic            accept;

  assign accept = in_valid && in_ready_q;

  // Lane r works on column t-r at compute cycle t; B reaches it through r skew registers.
  always_comb begin
    int d;
    d      = 0;
    b_head = '0;
    if (int'(cyc_q) < COLS) b_head = b_buf_q[BIW'(cyc_q)];
    lane_b[0] = b_head;
    for (int r = 1; r < ROWS; r++) lane_b[r] = skew_q[r-1];
    for (int r = 0; r < ROWS; r++) begin
      d          = int'(cyc_q) - r;
      lane_en[r] = (state_q == S_COMPUTE) && (d >= 0) && (d < COLS);
      lane_a[r]  = lane_en[r] ? a_buf_q[AIW'(r * COLS + d)] : '0;
    end
  end

  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    cyc_d       = cyc_q;
    load_done_d = load_done_q;
    b_buf_d     = b_buf_q;
    a_buf_d     = a_buf_q;
    skew_d      = skew_q;
    mac_clr     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_LOAD;
          beat_d      = '0;
          load_done_d = 1'b0;
          mac_clr     = 1'b1;
        end
      end
      S_LOAD: begin
        if (load_done_q) begin
          state_d = S_COMPUTE;
          cyc_d   = '0;
        end else if (accept) begin
          if (int'(beat_q) < COLS) b_buf_d[BIW'(beat_q)] = in_data;
          else a_buf_d[AIW'(int'(beat_q) - COLS)] = in_data;
          if (beat_q == BW'(NBEATS - 1)) load_done_d = 1'b1;
          else beat_d = beat_q + BW'(1);
        end
      end
      S_COMPUTE: begin
        skew_d[0] = b_head;
        for (int r = 1; r < ROWS; r++) skew_d[r] = skew_q[r-1];
        if (cyc_q == CW'(NCOMP - 1)) begin
          state_d = S_DRAIN;
          cyc_d   = '0;
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
      S_DRAIN: begin
        if (cyc_q == CW'(DRAIN_CYCLES - 1)) state_d = S_DONE;
        else cyc_d = cyc_q + CW'(1);
      end
      S_DONE: begin
        if (start) begin
          state_d     = S_LOAD;
          beat_d      = '0;
          load_done_d = 1'b0;
          mac_clr     = 1'b1;
        end else if (clr) begin
          state_d = S_IDLE;
          mac_clr = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    in_ready_d = (state_d == S_LOAD) && !load_done_d;
    c_valid_d  = (state_d == S_DONE);
    busy_d     = (state_d == S_LOAD) || (state_d == S_COMPUTE) || (state_d == S_DRAIN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      beat_q      <= '0;
      cyc_q       <= '0;
      load_done_q <= 1'b0;
      in_ready_q  <= 1'b0;
      c_valid_q   <= 1'b0;
      busy_q      <= 1'b0;
      b_buf_q     <= '{default: '0};
      a_buf_q     <= '{default: '0};
      skew_q      <= '{default: '0};
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      cyc_q       <= cyc_d;
      load_done_q <= load_done_d;
      in_ready_q  <= in_ready_d;
      c_valid_q   <= c_valid_d;
      busy_q      <= busy_d;
      b_buf_q     <= b_buf_d;
      a_buf_q     <= a_buf_d;
      skew_q      <= skew_d;
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_lane
    matvec_mac #(.DW(DW), .AW(AW)) u_mac (
      .clk (clk),
      .rst (rst),
      .en  (lane_en[r]),
      .clr (mac_clr),
      .a   (lane_a[r]),
      .b   (lane_b[r]),
      .acc (c_out[r*AW +: AW]),
      .ovf (ovf[r])
    );
  end

  assign in_ready = in_ready_q;
  assign c_valid  = c_valid_q;
  assign busy     = busy_q;
  assign state    = state_q;

endmodule

// File: tb/tb_matvec_engine.sv
// Scoreboard bench for matvec_engine: a 24-bit and a 16-bit instance share stimulus.
module tb_matvec_engine;

  logic         clk = 1'b0;
  logic         rst, start, clr, in_valid;
  logic [7:0]   in_data;
  logic         in_ready, c_valid, busy;
  logic [191:0] c_out;
  logic [7:0]   ovf;
  logic [2:0]   state;
  logic         in_ready16, c_valid16, busy16;
  logic [127:0] c_out16;
  logic [7:0]   ovf16;
  logic [2:0]   state16;

  always #5 clk = ~clk;

  matvec_engine #(.ROWS(8), .COLS(8), .DW(8), .AW(24)) u_dut (
    .clk(clk), .rst(rst), .start(start), .clr(clr), .in_valid(in_valid),
    .in_ready(in_ready), .in_data(in_data), .c_out(c_out), .c_valid(c_valid),
    .ovf(ovf), .busy(busy), .state(state));

  matvec_engine #(.ROWS(8), .COLS(8), .DW(8), .AW(16)) u_dut16 (
    .clk(clk), .rst(rst), .start(start), .clr(clr), .in_valid(in_valid),
    .in_ready(in_ready16), .in_data(in_data), .c_out(c_out16), .c_valid(c_valid16),
    .ovf(ovf16), .busy(busy16), .state(state16));

  typedef struct {
    string        name;
    bit           lat;
    logic [191:0] c24;
    logic [127:0] c16;
    logic [7:0]   o24;
    logic [7:0]   o16;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] stream[$];
  int checks = 0, failures = 0;
  int edge_cnt = 0, beat_cnt = 0, last_edge = 0;

  always @(posedge clk) begin
    edge_cnt <= edge_cnt + 1;
    if (in_valid && in_ready) beat_cnt <= beat_cnt + 1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic push_s2(input string nm);
    exp_t e;
    e.name = nm; e.lat = 1'b1; e.o24 = '0; e.o16 = '0;
    for (int r = 0; r < 8; r++) begin
      e.c24[r*24 +: 24] = 24'(8 * (r + 1));
      e.c16[r*16 +: 16] = 16'(8 * (r + 1));
    end
    sb.push_back(e);
  endtask

  task automatic push_uni(input string nm, input int v24, input int v16,
                          input logic [7:0] o24, input logic [7:0] o16);
    exp_t e;
    e.name = nm; e.lat = 1'b1; e.o24 = o24; e.o16 = o16;
    for (int r = 0; r < 8; r++) begin
      e.c24[r*24 +: 24] = 24'(v24);
      e.c16[r*16 +: 16] = 16'(v16);
    end
    sb.push_back(e);
  endtask

  task automatic build(input logic [7:0] bval, input int amode, input logic [7:0] aval);
    stream.delete();
    for (int c = 0; c < 8; c++) stream.push_back(bval);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) stream.push_back(amode == 1 ? 8'(r + 1) : aval);
  endtask

  task automatic monitor();
    logic prev;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (c_valid && !prev) begin
        if (sb.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_result actual=c_valid_rise required=none");
        end else begin
          e = sb.pop_front();
          for (int r = 0; r < 8; r++) begin
            chk($sformatf("%s_c24_lane%0d", e.name, r), 32'(c_out[r*24 +: 24]), 32'(e.c24[r*24 +: 24]));
            chk($sformatf("%s_c16_lane%0d", e.name, r), 32'(c_out16[r*16 +: 16]), 32'(e.c16[r*16 +: 16]));
          end
          chk({e.name, "_ovf24"}, 32'(ovf), 32'(e.o24));
          chk({e.name, "_ovf16"}, 32'(ovf16), 32'(e.o16));
          chk({e.name, "_cvalid16"}, 32'(c_valid16), 32'd1);
          if (e.lat) chk({e.name, "_latency"}, 32'(edge_cnt - last_edge), 32'd18);
        end
      end
      prev = c_valid;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic feed(input bit gaps, input bit poke);
    int idx, guard;
    bit ph;
    idx = 0; guard = 0; ph = 1'b1;
    while (idx < stream.size() && guard < 1000) begin
      in_valid = gaps ? ph : 1'b1;
      ph       = !ph;
      in_data  = stream[idx];
      start    = poke && (idx == 10);
      clr      = poke && (idx == 20);
      if (in_valid && in_ready) begin
        idx++;
        if (idx == stream.size()) last_edge = edge_cnt + 1;
      end
      @(negedge clk);
      guard++;
    end
    in_valid = 1'b0; start = 1'b0; clr = 1'b0;
    chk("feed_complete", 32'(idx), 32'(stream.size()));
  endtask

  task automatic wait_done(input string nm);
    int g;
    g = 0;
    while (!c_valid && g < 200) begin
      @(negedge clk);
      g++;
    end
    chk({nm, "_done_reached"}, 32'(c_valid), 32'd1);
  endtask

  task automatic run(input string nm, input bit gaps, input bit poke);
    int b0;
    b0 = beat_cnt;
    feed(gaps, poke);
    wait_done(nm);
    chk({nm, "_beats"}, 32'(beat_cnt - b0), 32'd72);
  endtask

  initial begin
    int b0;
    rst = 1'b1; start = 1'b0; clr = 1'b0; in_valid = 1'b0; in_data = '0;
    fork
      monitor();
    join_none
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_c_valid", 32'(c_valid), 32'd0);
    chk("rst_c_out_nonzero", 32'(|c_out), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst16_state", 32'(state16), 32'd0);
    chk("rst16_in_ready", 32'(in_ready16), 32'd0);
    chk("rst16_busy", 32'(busy16), 32'd0);

    // Basic run: B all 1, A[r][c] = r+1
    build(8'd1, 1, 8'd0);
    push_s2("s2");
    pulse_start();
    chk("s2_load_state", 32'(state), 32'd1);
    chk("s2_load_ready", 32'(in_ready), 32'd1);
    run("s2", 1'b0, 1'b0);
    chk("s2_done_state", 32'(state), 32'd4);
    chk("s2_done_ready", 32'(in_ready), 32'd0);
    chk("s2_done_busy", 32'(busy), 32'd0);

    // Gapped input, stray start/clr during LOAD and COMPUTE
    push_s2("s3");
    pulse_start();
    b0 = beat_cnt;
    feed(1'b1, 1'b1);
    repeat (2) @(negedge clk);
    chk("s3_compute_state", 32'(state), 32'd2);
    chk("s3_compute_ready", 32'(in_ready), 32'd0);
    chk("s3_compute_busy", 32'(busy), 32'd1);
    in_valid = 1'b1; in_data = 8'hFF; start = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; start = 1'b0;
    chk("s3_start_ignored", 32'(state), 32'd2);
    wait_done("s3");
    chk("s3_beats", 32'(beat_cnt - b0), 32'd72);

    // Reset in the middle of COMPUTE, then a clean rerun
    pulse_start();
    feed(1'b0, 1'b0);
    repeat (4) @(negedge clk);
    chk("s5_in_compute", 32'(state), 32'd2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("s5_rst_state", 32'(state), 32'd0);
    chk("s5_rst_c_out_nonzero", 32'(|c_out), 32'd0);
    chk("s5_rst_c16_nonzero", 32'(|c_out16), 32'd0);
    chk("s5_rst_c_valid", 32'(c_valid), 32'd0);
    chk("s5_rst_busy", 32'(busy), 32'd0);
    push_s2("s5_rerun");
    pulse_start();
    run("s5_rerun", 1'b0, 1'b0);

    // All elements 255: 8*255*255 = 520200 per lane
    build(8'd255, 0, 8'd255);
`ifdef MATVEC_SAT_EN
    push_uni("s4", 520200, 65535, 8'h00, 8'hFF);
`else
    push_uni("s4", 520200, 61448, 8'h00, 8'hFF);
`endif
    pulse_start();
    run("s4", 1'b0, 1'b0);

    // start and clr together in DONE: restart wins and clears acc/ovf
    start = 1'b1; clr = 1'b1;
    @(negedge clk);
    start = 1'b0; clr = 1'b0;
    chk("s6_restart_state", 32'(state), 32'd1);
    chk("s6_restart_ovf16", 32'(ovf16), 32'd0);
    chk("s6_restart_c16_nonzero", 32'(|c_out16), 32'd0);
    chk("s6_restart_c_valid", 32'(c_valid), 32'd0);
    build(8'd2, 0, 8'd1);
    push_uni("s6", 16, 16, 8'h00, 8'h00);
    run("s6", 1'b0, 1'b0);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("s6_clr_state", 32'(state), 32'd0);
    chk("s6_clr_c_out_nonzero", 32'(|c_out), 32'd0);
    chk("s6_clr_c_valid", 32'(c_valid), 32'd0);
    chk("s6_clr_ovf", 32'(ovf), 32'd0);

    repeat (2) @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/matvec_engine.md
Name: matvec_engine

Overview:
Parametrised successor to the fixed 8x8 FIFO/MAC matrix multiplier: computes C = A·B for a ROWS x COLS matrix A and a COLS-element vector B, both streamed in over one valid/ready port. ROWS MAC lanes are fed in a systolic, skewed order. Results appear on a flattened bus with a level-valid flag. Sits between the on-chip memory fetch path and the result capture/readback logic.

Parameters:
ROWS, 8, number of output lanes (rows of A); >= 1
COLS, 8, vector length (columns of A); >= 1
DW, 8, unsigned input element width
AW, 24, unsigned accumulator and output width per lane; AW >= 2*DW

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
start  in  1  begin a load/compute run; sampled in IDLE and DONE only
clr  in  1  clear results; sampled in DONE only
in_valid  in  1  in_data is valid
in_ready  out  1  engine accepts in_data this cycle
in_data  in  DW  B elements first, then A row-major
c_out  out  ROWS*AW  lane r at bits [r*AW +: AW]
c_valid  out  1  c_out holds the final result
ovf  out  ROWS  sticky per-lane overflow flag
busy  out  1  state is LOAD, COMPUTE or DRAIN
state  out  3  current FSM state, for debug

Behaviour:
- Reset, rst high at a clk edge: state=IDLE, and c_out, c_valid, ovf, in_ready, busy, counters and internal buffers all 0. Reset asserted mid-run aborts the run with the same result.
- State encoding: IDLE=0, LOAD=1, COMPUTE=2, DRAIN=3, DONE=4.
- IDLE: start=1 -> LOAD.
- LOAD: in_ready=1. Data is accepted on in_valid&&in_ready.
  - First COLS beats: B[0..COLS-1].
  - Next ROWS*COLS beats: A[r][c], r-major.
  - Gaps in in_valid are allowed. The beat count is exact.
  - The cycle after the final beat (beat index COLS+ROWS*COLS-1): -> COMPUTE. Accumulators are already 0.
- COMPUTE: lasts exactly ROWS+COLS-1 cycles.
  - On cycle t, lane r multiplies A[r][t-r] by B[t-r] when 0 <= t-r < COLS; otherwise the lane is idle.
  - The B element is forwarded lane-to-lane through a register chain.
  - After the last cycle -> DRAIN.
- MAC lane: 2-stage pipeline.
  - Stage 1: registered 2*DW-bit product.
  - Stage 2: acc <= acc + zero-extended product.
  - Default arithmetic is modulo 2^AW (wrap). ovf[r] is set when the AW-bit carry-out occurs and stays set until the next clear.
- DRAIN: 2 cycles to flush the pipeline, then -> DONE.
- DONE: c_valid=1; c_out holds the results.
  - start=1 -> LOAD, clearing acc and ovf on the same edge.
  - else clr=1 -> IDLE with c_out=0 and ovf=0.
  - start takes priority over clr.
- Latency: if the final input beat is accepted at edge T, c_valid rises at edge T+ROWS+COLS+2 (T+18 at defaults).
- start is ignored in LOAD/COMPUTE/DRAIN. clr is ignored outside DONE.
- in_ready=0 in every state except LOAD. in_valid outside LOAD is ignored.

Optional Feature:
MATVEC_SAT_EN
- Defined: accumulation saturates. If acc + product >= 2^AW, acc becomes 2^AW-1 and holds there; ovf[r] is set as usual.
- Undefined: wrap-around arithmetic as described above.
- Port list and timing are identical in both builds.

Decomposition:
- matvec_pkg: state_t enum (3-bit, encodings above); a localparam function giving the load beat count (COLS+ROWS*COLS); the compute cycle count (ROWS+COLS-1); DRAIN_CYCLES=2.
- Sub-module matvec_mac (params DW, AW): 2-stage multiply-accumulate, with en, clr and sticky ovf. The MATVEC_SAT_EN branch lives inside it.
- Top-level content: FSM, load counter, A storage (ROWS row buffers of depth COLS), B skew chain, and ROWS matvec_mac instances.

Test Plan:
1. Hold rst 3 cycles, then release -> state=0, in_ready=0, c_valid=0, c_out=0, ovf=0, busy=0.
2. Defaults; start; B all 1, A[r][c]=r+1, no gaps -> c_out lane r = 8*(r+1) (8,16,...,64), ovf=0. c_valid rises exactly 18 cycles after the last beat; exactly 72 beats accepted.
3. Same data as 2 with in_valid toggling every cycle, plus start pulses during LOAD and COMPUTE -> identical result; extra start pulses have no effect; in_ready low outside LOAD.
4. AW=16, all elements 255 -> each lane sum is 520200:
   - Without MATVEC_SAT_EN: every lane = 61448, ovf=8'hFF.
   - With MATVEC_SAT_EN: every lane = 65535, ovf=8'hFF.
   - Default AW=24: every lane = 520200, ovf=0.
5. Assert rst for 1 cycle in the middle of COMPUTE -> state=IDLE and c_out=0 next edge. A following full run with the data from scenario 2 gives the scenario 2 results.
6. In DONE, assert start and clr in the same cycle -> LOAD with acc and ovf cleared. A second run with B all 2 and A[r][c]=1 -> all lanes 16. In DONE, clr alone -> IDLE, c_out=0, c_valid=0.
